// File: rtl/fir_serial_mac.sv
// Serial FIR filter. One time-shared multiplier walks the taps one per
// enabled cycle. The result is rounded, arithmetically shifted and
// saturated to DW bits. Coefficients live in registers so that reset can
// restore a pass-through response.
module fir_serial_mac #(
  parameter int DW    = 16,
  parameter int CW    = 8,
  parameter int TAPS  = 4,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in,
  output logic                    out_valid,
  output logic signed [DW-1:0]    out,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic signed [CW-1:0]    coef_wdata,
  output logic                    coef_err,
  output logic                    busy
);

  localparam int TW = $clog2(TAPS);
  localparam int PW = DW + CW;
  localparam int AW = DW + CW + TW;
  // Extra headroom so that adding the rounding constant can never wrap,
  // even for the largest shift amounts.
  localparam int SW = AW + CW + 1;

  localparam logic [SW-1:0]        ONE_SW = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] RND    = (ONE_SW << SHIFT) >> 1;
  localparam logic signed [SW-1:0] MAXV   = (ONE_SW << (DW-1)) - ONE_SW;
  localparam logic signed [SW-1:0] MINV   = ~MAXV;
  localparam logic [CW-1:0]        C_ONE  = {{(CW-1){1'b0}}, 1'b1} << SHIFT;
  localparam logic [TW-1:0]        LAST_K = TW'(TAPS - 1);
  localparam logic [TW:0]          TAPS_W = (TW+1)'(TAPS);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  dly_q [TAPS];
  logic signed [DW-1:0]  dly_d [TAPS];
  logic signed [CW-1:0]  coef_q [TAPS];
  logic signed [CW-1:0]  coef_d [TAPS];
  logic signed [DW-1:0]  out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  coef_err_q, coef_err_d;

  logic signed [PW-1:0]  prod_w;
  logic signed [SW-1:0]  sum_w;
  logic signed [SW-1:0]  shf_w;
  logic signed [DW-1:0]  sat_w;
  logic                  accept;
  logic                  addr_ok;

  assign in_ready  = (state_q == ST_IDLE) && enable && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign coef_err  = coef_err_q;
  assign addr_ok   = ({1'b0, coef_addr} < TAPS_W);

  // Single shared multiplier; coefficient and sample both selected by the tap counter.
  always_comb begin
    prod_w = coef_q[cnt_q] * dly_q[cnt_q];
  end

  // Round, shift and clamp the accumulator into the output range.
  always_comb begin
    sum_w = {{(SW-AW){acc_q[AW-1]}}, acc_q} + RND;
    shf_w = sum_w >>> SHIFT;
    if (shf_w > MAXV) begin
      sat_w = MAXV[DW-1:0];
    end else if (shf_w < MINV) begin
      sat_w = MINV[DW-1:0];
    end else begin
      sat_w = shf_w[DW-1:0];
    end
  end

  // Next-state logic: handshake, MAC sequencing, and coefficient writes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dly_d       = dly_q;
    coef_d      = coef_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    coef_err_d  = 1'b0;
    if (enable) begin
      if (coef_we) begin
        if ((state_q == ST_IDLE) && addr_ok) begin
          coef_d[coef_addr] = coef_wdata;
        end else begin
          coef_err_d = 1'b1;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            for (int i = TAPS - 1; i > 0; i--) begin
              dly_d[i] = dly_q[i-1];
            end
            dly_d[0] = in;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_MAC;
          end
        end
        ST_MAC: begin
          acc_d = acc_q + {{(AW-PW){prod_w[PW-1]}}, prod_w};
          if (cnt_q == LAST_K) begin
            cnt_d   = '0;
            state_d = ST_OUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_OUT: begin
          out_d       = sat_w;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers; reset restores a pass-through filter with an empty delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dly_q[i]  <= '0;
        coef_q[i] <= (i == 0) ? C_ONE : '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      coef_err_q  <= coef_err_d;
      for (int i = 0; i < TAPS; i++) begin
        dly_q[i]  <= dly_d[i];
        coef_q[i] <= coef_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac at DW=16, CW=8, TAPS=4, SHIFT=0.
module tb_fir_serial_mac;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_s;
  logic               out_valid;
  logic signed [15:0] out_s;
  logic               coef_we;
  logic [1:0]         coef_addr;
  logic signed [7:0]  coef_wdata;
  logic               coef_err;
  logic               busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit                 load;
    logic [3:0][7:0]    c;
    logic signed [15:0] x;
    logic signed [15:0] y;
  } vec_t;

  vec_t tbl [26];

  fir_serial_mac #(.DW(16), .CW(8), .TAPS(4), .SHIFT(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_s),
    .out_valid (out_valid),
    .out       (out_s),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
    .coef_err  (coef_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input bit ld, input int c0, input int c1, input int c2,
                              input int c3, input int x, input int y);
    vec_t v;
    v.load = ld;
    v.c[0] = c0[7:0];
    v.c[1] = c1[7:0];
    v.c[2] = c2[7:0];
    v.c[3] = c3[7:0];
    v.x    = x[15:0];
    v.y    = y[15:0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts and ends on a falling edge.
  task automatic wr_coef(input int addr, input int data, input int exp_err, input string name);
    coef_we    = 1'b1;
    coef_addr  = 2'(addr);
    coef_wdata = 8'(data);
    @(negedge clk);
    chk(name, int'(coef_err), exp_err);
    coef_we = 1'b0;
    $display("coef write c[%0d]=%0d coef_err=%0d", addr, data, coef_err);
  endtask

  // Waits (bounded) for out_valid and checks the value; ends one cycle after the strobe.
  task automatic wait_result(input int exp_y, input string name);
    int g = 0;
    while (!out_valid && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk({name, "_seen"}, int'(out_valid), 1);
    chk({name, "_out"}, int'(out_s), exp_y);
    $display("result %s out=%0d", name, out_s);
    @(negedge clk);
    chk({name, "_pulse"}, int'(out_valid), 0);
  endtask

  // Offers one sample, optionally stalls enable, checks latency, value and pulse width.
  task automatic run_sample(input int x, input int exp_y, input int stall_len,
                            input int exp_lat, input string name);
    int  lat  = 0;
    bit  seen = 1'b0;
    int  g    = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk({name, "_ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_s     = 16'(x);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        if (stall_len > 0 && lat == 1) enable = 1'b0;
        if (stall_len > 0 && lat == 1 + stall_len) enable = 1'b1;
        if (!enable) chk({name, "_busy_stall"}, int'(busy), 1);
      end
    end
    enable = 1'b1;
    chk({name, "_seen"}, int'(seen), 1);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_out"}, int'(out_s), exp_y);
    $display("sample %s in=%0d out=%0d latency=%0d", name, x, out_s, lat);
    @(negedge clk);
    chk({name, "_pulse"}, int'(out_valid), 0);
    chk({name, "_hold"}, int'(out_s), exp_y);
  endtask

  initial begin
    int ov;
    rst        = 1'b1;
    enable     = 1'b1;
    in_valid   = 1'b0;
    in_s       = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;

    // Pass-through, impulse response, mixed data, saturation, negative boundary.
    tbl[0]  = mk(0,    0,   0,   0,   0,   1234,   1234);
    tbl[1]  = mk(1,    3, -10,   4, -17,      0, -12340);
    tbl[2]  = mk(0,    0,   0,   0,   0,      0,   4936);
    tbl[3]  = mk(0,    0,   0,   0,   0,      0, -20978);
    tbl[4]  = mk(0,    0,   0,   0,   0,      0,      0);
    tbl[5]  = mk(0,    0,   0,   0,   0,      1,      3);
    tbl[6]  = mk(0,    0,   0,   0,   0,      0,    -10);
    tbl[7]  = mk(0,    0,   0,   0,   0,      0,      4);
    tbl[8]  = mk(0,    0,   0,   0,   0,      0,    -17);
    tbl[9]  = mk(0,    0,   0,   0,   0,    100,    300);
    tbl[10] = mk(0,    0,   0,   0,   0,    -50,  -1150);
    tbl[11] = mk(0,    0,   0,   0,   0,      7,    921);
    tbl[12] = mk(0,    0,   0,   0,   0,      2,  -1964);
    tbl[13] = mk(1,  127, 127, 127, 127,  32767,  32767);
    tbl[14] = mk(0,    0,   0,   0,   0,  32767,  32767);
    tbl[15] = mk(0,    0,   0,   0,   0,  32767,  32767);
    tbl[16] = mk(0,    0,   0,   0,   0,  32767,  32767);
    tbl[17] = mk(1, -128,-128,-128,-128,  32767, -32768);
    tbl[18] = mk(0,    0,   0,   0,   0,  32767, -32768);
    tbl[19] = mk(0,    0,   0,   0,   0,  32767, -32768);
    tbl[20] = mk(0,    0,   0,   0,   0,  32767, -32768);
    tbl[21] = mk(1,    1,   2,   3,   4,      0,  32767);
    tbl[22] = mk(0,    0,   0,   0,   0,      0,  32767);
    tbl[23] = mk(0,    0,   0,   0,   0,      0,  32767);
    tbl[24] = mk(0,    0,   0,   0,   0,      0,      0);
    tbl[25] = mk(0,    0,   0,   0,   0, -32768, -32768);

    repeat (3) @(negedge clk);
    chk("rst_out", int'(out_s), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_coef_err", int'(coef_err), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 26; i++) begin
      if (tbl[i].load) begin
        for (int k = 0; k < 4; k++) begin
          wr_coef(k, int'($signed(tbl[i].c[k])), 0, $sformatf("vec%0d_coef%0d_err", i, k));
        end
      end
      run_sample(int'(tbl[i].x), int'(tbl[i].y), 0, 5, $sformatf("vec%0d", i));
    end

    // Drain the negative sample, then leave the delay line empty.
    run_sample(0, -32768, 0, 5, "neg_sat1");
    run_sample(0, -32768, 0, 5, "neg_sat2");
    run_sample(0, -32768, 0, 5, "neg_sat3");
    run_sample(0, 0, 0, 5, "neg_flush");

    // Coefficient write while busy is dropped and flagged once.
    in_valid = 1'b1;
    in_s     = 16'sd10;
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    chk("macwr_busy", int'(busy), 1);
    coef_we    = 1'b1;
    coef_addr  = 2'd0;
    coef_wdata = 8'sd5;
    @(negedge clk);
    chk("macwr_err_pulse", int'(coef_err), 1);
    coef_we = 1'b0;
    @(negedge clk);
    chk("macwr_err_once", int'(coef_err), 0);
    wait_result(10, "macwr");
    run_sample(0, 20, 0, 5, "macwr_old_coef");

    // Write and accept in the same idle cycle: the new c[0] applies to this sample.
    coef_we    = 1'b1;
    coef_addr  = 2'd0;
    coef_wdata = 8'sd7;
    in_valid   = 1'b1;
    in_s       = 16'sd1;
    @(posedge clk);
    @(negedge clk);
    coef_we  = 1'b0;
    in_valid = 1'b0;
    chk("samecyc_err", int'(coef_err), 0);
    wait_result(37, "samecyc");

    // Enable low for three cycles mid-MAC stretches latency to eight.
    run_sample(0, 42, 3, 8, "stall");

    // Reset in the middle of a MAC sequence.
    in_valid = 1'b1;
    in_s     = 16'sd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out", int'(out_s), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_in_ready_hold", int'(in_ready), 0);
    rst = 1'b0;
    ov  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("midrst_no_result", ov, 0);
    $display("reset mid-MAC: out=%0d busy=%0d", out_s, busy);
    run_sample(5, 5, 0, 5, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
